// File: rtl/map_pkg.sv
// Shared register addresses and switch-state encoding for the mapper select controller.
package map_pkg;

    localparam logic [3:0] REG_MAPPER = 4'd0;
    localparam logic [3:0] REG_LOADER = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_MATCH  = 3'd2,
        ST_SWITCH = 3'd3,
        ST_HOLD   = 3'd4
    } sw_state_t;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchroniser for an asynchronous level, with one-clk rise and fall strobes.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the asynchronous input through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise = (sync_q[2:1] == 2'b01);
    assign fall = (sync_q[2:1] == 2'b10);

endmodule

// File: rtl/map_switch.sv
// Mapper selection controller: arms a pending slot from host writes and switches on the CPU launch signature.
module map_switch
    import map_pkg::*;
#(
    parameter int          MAP_CNT        = 32,
    parameter int          ADDR_BITS      = 23,
    parameter int          ARG_BITS       = 2,
    parameter logic [15:0] TRIG_ADDR      = 16'hFFFC,
    parameter logic [7:0]  TRIG_LO        = 8'hFC,
    parameter logic [7:0]  TRIG_HI        = 8'hFF,
    parameter int          HOLD_M2        = 4,
    parameter int          IDLE_CLKS      = 1024,
    parameter bit          REVERT_ON_IDLE = 1'b1,
    localparam int         SEL_BITS       = $clog2(MAP_CNT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m2,
    input  logic [15:0]          cpu_addr,
    input  logic [7:0]           cpu_data,
    input  logic                 cpu_rw,
    input  logic [31:0]          wr_reg,
    input  logic [3:0]           wr_reg_addr,
    input  logic                 wr_reg_changed,
    output logic [SEL_BITS-1:0]  select,
    output logic [MAP_CNT-1:0]   map_reset,
    output logic [ARG_BITS-1:0]  map_args,
    output logic [ADDR_BITS-1:0] prg_mask,
    output logic [ADDR_BITS-1:0] chr_base,
    output logic                 loader_buffer_num,
    output logic                 loader_prelaunch,
    output logic                 armed,
    output logic                 cpu_idle
);

    localparam int CHR_BITS = 5;
    localparam int FIELD_W  = ARG_BITS + CHR_BITS + SEL_BITS;
    localparam int IDLE_W   = $clog2(IDLE_CLKS + 1);
    localparam int HOLD_W   = $clog2(HOLD_M2 + 1);
    localparam logic [MAP_CNT-1:0] LOADER_ONLY = {{(MAP_CNT-1){1'b1}}, 1'b0};

    logic m2_fall_s, m2_rise_unused, wr_rise_s, wr_fall_s, wr_edge_s;

    sync_edge u_sync_m2 (.clk(clk), .reset(reset), .din(m2),
                         .rise(m2_rise_unused), .fall(m2_fall_s));
    sync_edge u_sync_wr (.clk(clk), .reset(reset), .din(wr_reg_changed),
                         .rise(wr_rise_s), .fall(wr_fall_s));
    assign wr_edge_s = wr_rise_s | wr_fall_s;

    sw_state_t             state_q, state_d;
    logic [SEL_BITS-1:0]   select_q, select_d, pending_q, pending_d;
    logic [MAP_CNT-1:0]    map_reset_q, map_reset_d;
    logic [ARG_BITS-1:0]   map_args_q, map_args_d;
    logic [CHR_BITS-1:0]   chr_off_q, chr_off_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                  buffer_num_q, buffer_num_d, prelaunch_q, prelaunch_d;
    logic                  cpu_idle_q, cpu_idle_d;
    logic                  revert_s, trig_lo_s, pend_ok_s, wr_reg_unused;
    logic [SEL_BITS-1:0]   wr_pending_s;
    logic [31:0]           one_shl_s;

    assign wr_reg_unused = ^wr_reg[31:FIELD_W];
    assign wr_pending_s  = wr_reg[SEL_BITS-1:0];
    // Non-power-of-two slot counts leave encodings with no mapper behind them.
    assign pend_ok_s     = (32'(wr_pending_s) < 32'(MAP_CNT));
    assign trig_lo_s     = m2_fall_s && cpu_rw && (cpu_addr == TRIG_ADDR) && (cpu_data == TRIG_LO);

    // Next-state logic: idle watchdog, launch FSM, then host writes (revert overrides writes).
    always_comb begin
        state_d      = state_q;
        select_d     = select_q;
        pending_d    = pending_q;
        map_reset_d  = map_reset_q;
        map_args_d   = map_args_q;
        chr_off_d    = chr_off_q;
        hold_d       = hold_q;
        buffer_num_d = buffer_num_q;
        prelaunch_d  = 1'b0;

        if (m2_fall_s) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_W'(IDLE_CLKS)) begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
        cpu_idle_d = (idle_cnt_d == IDLE_W'(IDLE_CLKS));
        revert_s   = REVERT_ON_IDLE && cpu_idle_d && !cpu_idle_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_ARMED: begin
                if (trig_lo_s) begin
                    state_d = ST_MATCH;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_MATCH: begin
                if (m2_fall_s && cpu_rw) begin
                    state_d = (cpu_data == TRIG_HI) ? ST_SWITCH : ST_ARMED;
                end else begin
                    state_d = ST_MATCH;
                end
            end
            ST_SWITCH: begin
                select_d    = pending_q;
                map_reset_d = '1;
                hold_d      = HOLD_W'(HOLD_M2);
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (m2_fall_s && (hold_q <= HOLD_W'(1))) begin
                    map_reset_d = ~(MAP_CNT'(1) << select_q);
                    hold_d      = '0;
                    state_d     = ST_IDLE;
                end else if (m2_fall_s) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (revert_s) begin
            select_d    = '0;
            map_args_d  = '0;
            chr_off_d   = '0;
            map_reset_d = LOADER_ONLY;
            hold_d      = '0;
            state_d     = ST_IDLE;
        end else if (wr_edge_s && (wr_reg_addr == REG_MAPPER)) begin
            {map_args_d, chr_off_d, pending_d} = wr_reg[FIELD_W-1:0];
            // A write during an in-flight switch lets the hold finish rather than strand resets.
            if ((state_q != ST_SWITCH) && (state_q != ST_HOLD)) begin
                state_d = pend_ok_s ? ST_ARMED : ST_IDLE;
            end else begin
                state_d = state_d;
            end
        end else if (wr_edge_s && (wr_reg_addr == REG_LOADER)) begin
            buffer_num_d = wr_reg[0];
            prelaunch_d  = wr_reg[1];
        end else begin
            pending_d = pending_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            select_q     <= '0;
            pending_q    <= '0;
            map_reset_q  <= LOADER_ONLY;
            map_args_q   <= '0;
            chr_off_q    <= '0;
            hold_q       <= '0;
            idle_cnt_q   <= '0;
            buffer_num_q <= 1'b0;
            prelaunch_q  <= 1'b0;
            cpu_idle_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            select_q     <= select_d;
            pending_q    <= pending_d;
            map_reset_q  <= map_reset_d;
            map_args_q   <= map_args_d;
            chr_off_q    <= chr_off_d;
            hold_q       <= hold_d;
            idle_cnt_q   <= idle_cnt_d;
            buffer_num_q <= buffer_num_d;
            prelaunch_q  <= prelaunch_d;
            cpu_idle_q   <= cpu_idle_d;
        end
    end

    assign one_shl_s = 32'd1 << chr_off_q;
    assign prg_mask  = (chr_off_q == '0) ? {ADDR_BITS{1'b1}} : ADDR_BITS'(one_shl_s - 32'd1);
    assign chr_base  = (chr_off_q == '0) ? {ADDR_BITS{1'b0}} : ADDR_BITS'(one_shl_s);

    assign select            = select_q;
    assign map_reset         = map_reset_q;
    assign map_args          = map_args_q;
    assign loader_buffer_num = buffer_num_q;
    assign loader_prelaunch  = prelaunch_q;
    assign armed             = (state_q == ST_ARMED) || (state_q == ST_MATCH);
    assign cpu_idle          = cpu_idle_q;

endmodule

// File: tb/tb_map_switch.sv
// Directed bench for map_switch: register decode, launch signature, reset hold, loader pulse, idle revert.
module tb_map_switch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m2 = 1'b0;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_data = 8'h00;
    logic        cpu_rw = 1'b1;
    logic [31:0] wr_reg = 32'h0;
    logic [3:0]  wr_reg_addr = 4'd0;
    logic        wr_reg_changed = 1'b0;
    logic [4:0]  select;
    logic [31:0] map_reset;
    logic [1:0]  map_args;
    logic [22:0] prg_mask, chr_base;
    logic        loader_buffer_num, loader_prelaunch, armed, cpu_idle;

    int pass_cnt = 0;
    int total_cnt = 0;

    map_switch dut (
        .clk(clk), .reset(reset), .m2(m2), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_rw(cpu_rw), .wr_reg(wr_reg), .wr_reg_addr(wr_reg_addr),
        .wr_reg_changed(wr_reg_changed), .select(select), .map_reset(map_reset),
        .map_args(map_args), .prg_mask(prg_mask), .chr_base(chr_base),
        .loader_buffer_num(loader_buffer_num), .loader_prelaunch(loader_prelaunch),
        .armed(armed), .cpu_idle(cpu_idle)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        cpu_addr = a;
        cpu_data = d;
        cpu_rw   = rw;
        m2       = 1'b1;
        wait_clks(4);
        m2 = 1'b0;
        wait_clks(5);
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] v);
        wr_reg         = v;
        wr_reg_addr    = a;
        wr_reg_changed = ~wr_reg_changed;
        wait_clks(6);
    endtask

    task automatic test_reset();
        wait_clks(3);
        total_cnt++;
        if (cpu_idle !== 1'b1) $display("FAIL reset_cpu_idle: got %b want 1", cpu_idle);
        else pass_cnt++;
        total_cnt++;
        if (select !== 5'd0) $display("FAIL reset_select: got %0d want 0", select);
        else pass_cnt++;
        total_cnt++;
        if (map_reset !== 32'hFFFF_FFFE) $display("FAIL reset_map_reset: got %h want fffffffe", map_reset);
        else pass_cnt++;
        total_cnt++;
        if ({armed, loader_prelaunch, loader_buffer_num, map_args} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {armed, loader_prelaunch, loader_buffer_num, map_args});
        else pass_cnt++;
        total_cnt++;
        if (prg_mask !== 23'h7FFFFF || chr_base !== 23'h0)
            $display("FAIL reset_shape: got mask %h base %h want 7fffff 0", prg_mask, chr_base);
        else pass_cnt++;
        reset = 1'b0;
        wait_clks(2);
    endtask

    task automatic test_mapper_write();
        reg_write(4'd0, 32'h0A3);
        total_cnt++;
        if (armed !== 1'b1 || select !== 5'd0)
            $display("FAIL mapper_arm: got armed %b select %0d want 1 0", armed, select);
        else pass_cnt++;
        total_cnt++;
        if (prg_mask !== 23'h1F || chr_base !== 23'h20 || map_args !== 2'd0)
            $display("FAIL mapper_shape: got mask %h base %h args %0d want 1f 20 0", prg_mask, chr_base, map_args);
        else pass_cnt++;
    endtask

    task automatic test_hold(input logic [4:0] slot);
        for (int i = 0; i < 3; i++) begin
            cpu_cycle(16'h8000, 8'h00, 1'b1);
            total_cnt++;
            if (map_reset !== 32'hFFFF_FFFF)
                $display("FAIL hold_%0d_slot%0d: got %h want ffffffff", i, slot, map_reset);
            else pass_cnt++;
        end
        cpu_cycle(16'h8000, 8'h00, 1'b1);
        total_cnt++;
        if (map_reset !== ~(32'd1 << slot))
            $display("FAIL hold_release_slot%0d: got %h want %h", slot, map_reset, ~(32'd1 << slot));
        else pass_cnt++;
    endtask

    task automatic test_switch();
        cpu_cycle(16'hFFFC, 8'hFC, 1'b1);
        total_cnt++;
        if (armed !== 1'b1 || select !== 5'd0)
            $display("FAIL switch_half: got armed %b select %0d want 1 0", armed, select);
        else pass_cnt++;
        cpu_cycle(16'hFFFD, 8'hFF, 1'b1);
        total_cnt++;
        if (select !== 5'd3 || armed !== 1'b0 || map_reset !== 32'hFFFF_FFFF)
            $display("FAIL switch_done: got select %0d armed %b rst %h want 3 0 ffffffff", select, armed, map_reset);
        else pass_cnt++;
        test_hold(5'd3);
    endtask

    task automatic test_mismatch();
        reg_write(4'd0, 32'h0A5);
        cpu_cycle(16'hFFFC, 8'hFC, 1'b1);
        cpu_cycle(16'h1234, 8'h00, 1'b1);
        total_cnt++;
        if (armed !== 1'b1 || select !== 5'd3)
            $display("FAIL mismatch_rearm: got armed %b select %0d want 1 3", armed, select);
        else pass_cnt++;
        cpu_cycle(16'hFFFD, 8'hFF, 1'b1);
        total_cnt++;
        if (armed !== 1'b1 || select !== 5'd3)
            $display("FAIL mismatch_lone_hi: got armed %b select %0d want 1 3", armed, select);
        else pass_cnt++;
        cpu_cycle(16'hFFFC, 8'hFC, 1'b1);
        cpu_cycle(16'h2000, 8'h00, 1'b0);
        cpu_cycle(16'hFFFD, 8'hFF, 1'b1);
        total_cnt++;
        if (select !== 5'd5 || armed !== 1'b0)
            $display("FAIL mismatch_switch: got select %0d armed %b want 5 0", select, armed);
        else pass_cnt++;
        test_hold(5'd5);
    endtask

    task automatic test_chr_off_zero();
        reg_write(4'd0, 32'h403);
        total_cnt++;
        if (prg_mask !== 23'h7FFFFF || chr_base !== 23'h0 || map_args !== 2'd1 || armed !== 1'b1)
            $display("FAIL chr0_shape: got mask %h base %h args %0d armed %b want 7fffff 0 1 1",
                     prg_mask, chr_base, map_args, armed);
        else pass_cnt++;
        cpu_cycle(16'hFFFC, 8'hFC, 1'b1);
        cpu_cycle(16'hFFFD, 8'hFF, 1'b1);
        total_cnt++;
        if (select !== 5'd3) $display("FAIL chr0_switch: got select %0d want 3", select);
        else pass_cnt++;
        test_hold(5'd3);
    endtask

    task automatic test_loader();
        int highs;
        wr_reg = 32'h3; wr_reg_addr = 4'd1; wr_reg_changed = ~wr_reg_changed;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (loader_prelaunch === 1'b1) highs++;
        end
        total_cnt++;
        if (highs != 1 || loader_buffer_num !== 1'b1)
            $display("FAIL loader_pulse: got %0d clks buf %b want 1 1", highs, loader_buffer_num);
        else pass_cnt++;
        wr_reg = 32'h1; wr_reg_changed = ~wr_reg_changed;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (loader_prelaunch === 1'b1) highs++;
        end
        total_cnt++;
        if (highs != 0 || loader_buffer_num !== 1'b1)
            $display("FAIL loader_no_pulse: got %0d clks buf %b want 0 1", highs, loader_buffer_num);
        else pass_cnt++;
    endtask

    task automatic test_idle();
        wait_clks(950);
        total_cnt++;
        if (cpu_idle !== 1'b0 || select !== 5'd3)
            $display("FAIL idle_early: got idle %b select %0d want 0 3", cpu_idle, select);
        else pass_cnt++;
        wait_clks(100);
        total_cnt++;
        if (cpu_idle !== 1'b1) $display("FAIL idle_flag: got %b want 1", cpu_idle);
        else pass_cnt++;
        total_cnt++;
        if (select !== 5'd0 || map_reset !== 32'hFFFF_FFFE || map_args !== 2'd0 || armed !== 1'b0)
            $display("FAIL idle_revert: got select %0d rst %h args %0d armed %b want 0 fffffffe 0 0",
                     select, map_reset, map_args, armed);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mapper_write();
        test_switch();
        test_mismatch();
        test_chr_off_zero();
        test_loader();
        test_idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
